// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA core: datapath widths and the
// exponentiation controller state encoding.
// No ports; imported by mod_exp_ctrl and its neighbours at the RSA core top.
package rsa_pkg;

  // Operand width (N, y, result), exponent bits processed, engine k-input width.
  localparam int RSA_W  = 256;
  localparam int RSA_K  = 256;
  localparam int RSA_KW = 9;

  // Exponentiation controller states. Encodings 7 is unused and recovers to IDLE.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CHECK    = 3'd1,
    S_MUL_REQ  = 3'd2,
    S_MUL_WAIT = 3'd3,
    S_SQR_REQ  = 3'd4,
    S_SQR_WAIT = 3'd5,
    S_DONE     = 3'd6
  } exp_state_e;

endpackage

// File: rtl/mod_exp_ctrl.sv
// Modular exponentiation sequencer: y^d mod N via right-to-left square-and-multiply.
// Latency: 1 + K CHECK cycles + per-request (REQ + engine latency) + 1 DONE cycle.
// Backpressure: one exponentiation in flight; i_start ignored while busy, engine
//   handshake is a one-cycle o_mul_valid pulse answered by a one-cycle i_mul_ready.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_start               start request, sampled only in IDLE
//   i_n, i_y, i_d         modulus, base, exponent (captured on accepted start)
//   o_busy, o_done        busy level, one-cycle result-valid pulse
//   o_result              y^d mod N, held until the next result
//   o_mul_valid           one-cycle request pulse to the shared product engine
//   o_mul_n/a/b/k         engine operands, registered and stable for the whole request
//   i_mul_result          engine product a*b mod N
//   i_mul_ready           engine completion pulse
module mod_exp_ctrl
  import rsa_pkg::*;
#(
  parameter int W  = RSA_W,
  parameter int K  = RSA_K,
  parameter int KW = RSA_KW
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [W-1:0]  i_n,
  input  logic [W-1:0]  i_y,
  input  logic [K-1:0]  i_d,
  output logic          o_busy,
  output logic          o_done,
  output logic [W-1:0]  o_result,
  output logic          o_mul_valid,
  output logic [W-1:0]  o_mul_n,
  output logic [W-1:0]  o_mul_a,
  output logic [W-1:0]  o_mul_b,
  output logic [KW-1:0] o_mul_k,
  input  logic [W-1:0]  i_mul_result,
  input  logic          i_mul_ready
);

  exp_state_e state_q, state_d;

  logic [W-1:0]  n_q, n_d;        // captured modulus
  logic [K-1:0]  d_q, d_d;        // captured exponent
  logic [W-1:0]  m_q, m_d;        // accumulator
  logic [W-1:0]  t_q, t_d;        // running square y^(2^bit)
  logic [KW-1:0] bit_q, bit_d;    // exponent bit under examination
  logic [W-1:0]  a_q, a_d;        // engine multiplier operand
  logic [W-1:0]  b_q, b_d;        // engine multiplicand operand
  logic [W-1:0]  result_q, result_d;

  logic cur_bit;
  logic last_bit;

  assign cur_bit  = |(d_q & (K'(1) << bit_q));
  assign last_bit = (bit_q == KW'(K - 1));

  // ---------------------------------------------------------------------------
  // Next-state and datapath updates
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    d_d      = d_q;
    m_d      = m_q;
    t_d      = t_q;
    bit_d    = bit_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          n_d     = i_n;
          d_d     = i_d;
          m_d     = W'(1);
          t_d     = i_y;
          bit_d   = '0;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (cur_bit) begin
          // Operands are loaded on the way into the REQ state so they are
          // already registered when o_mul_valid rises.
          a_d     = m_q;
          b_d     = t_q;
          state_d = S_MUL_REQ;
        end else if (last_bit) begin
          result_d = m_q;
          state_d  = S_DONE;
        end else if (d_q == '0) begin
          // A zero exponent never multiplies, so its squares are dead work:
          // walk the bit index without touching the engine.
          bit_d = bit_q + KW'(1);
        end else begin
          a_d     = t_q;
          b_d     = t_q;
          state_d = S_SQR_REQ;
        end
      end

      S_MUL_REQ: state_d = S_MUL_WAIT;

      S_MUL_WAIT: begin
        if (i_mul_ready) begin
          m_d = i_mul_result;
          if (last_bit) begin
            // The square after the top bit is never needed; finish directly.
            result_d = i_mul_result;
            state_d  = S_DONE;
          end else begin
            a_d     = t_q;
            b_d     = t_q;
            state_d = S_SQR_REQ;
          end
        end
      end

      S_SQR_REQ: state_d = S_SQR_WAIT;

      S_SQR_WAIT: begin
        if (i_mul_ready) begin
          t_d     = i_mul_result;
          bit_d   = bit_q + KW'(1);
          state_d = S_CHECK;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and operand registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      d_q      <= '0;
      m_q      <= '0;
      t_q      <= '0;
      bit_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      d_q      <= d_d;
      m_q      <= m_d;
      t_q      <= t_d;
      bit_q    <= bit_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Each REQ state lasts exactly one cycle and is always followed by a WAIT
  // state, so the valid pulse can never be two cycles wide.
  assign o_mul_valid = (state_q == S_MUL_REQ) || (state_q == S_SQR_REQ);
  assign o_busy      = (state_q != S_IDLE);
  assign o_done      = (state_q == S_DONE);
  assign o_result    = result_q;
  assign o_mul_n     = n_q;
  assign o_mul_a     = a_q;
  assign o_mul_b     = b_q;
  assign o_mul_k     = KW'(W);

endmodule
